// File: rtl/ctr867_pkg.sv
// Shared types for the dual-chip counter sequencer: opcodes, chip S-select codes, FSM states.
package ctr867_pkg;

    typedef enum logic [1:0] {
        OP_CLR  = 2'b00,
        OP_DEC  = 2'b01,
        OP_LOAD = 2'b10,
        OP_INC  = 2'b11
    } op_e;

    // S=00 clears the chip asynchronously; S_UP with enables high doubles as HOLD.
    localparam logic [1:0] S_CLR  = 2'b00;
    localparam logic [1:0] S_DOWN = 2'b01;
    localparam logic [1:0] S_LOAD = 2'b10;
    localparam logic [1:0] S_UP   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        LOAD_LO,
        LOAD_HI
    } state_e;

endpackage

// File: rtl/ctr867_arbiter.sv
// Requester arbiter: one-hot grant, round-robin when CTR867_SEQ_RR_EN is defined, else fixed priority.
module ctr867_arbiter
    import ctr867_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               asyncResetN,
    input  logic [NUM_REQ-1:0] req,
    input  logic               grant_en,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] base;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W:0]   cand;
    logic             found;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
`ifdef CTR867_SEQ_RR_EN
        base = ptr_q;
`else
        base = '0;
`endif
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, base} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
            if (!found && req[cand[PTR_W-1:0]]) begin
                grant[cand[PTR_W-1:0]] = 1'b1;
                gnt_idx                = cand[PTR_W-1:0];
                found                  = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (grant_en && found) begin
            ptr_d = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge asyncResetN) begin
        if (!asyncResetN) ptr_q <= '0;
        else              ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ctr867_sequencer.sv
// Serialises requester commands onto a cascaded pair of 8-bit up/down counter chips.
// Build option: define CTR867_SEQ_RR_EN for round-robin arbitration (default fixed priority).
module ctr867_sequencer
    import ctr867_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                  clk,
    input  logic                  asyncResetN,
    input  logic [NUM_REQ-1:0]    reqValid,
    input  logic [2*NUM_REQ-1:0]  reqOp,
    input  logic [16*NUM_REQ-1:0] reqData,
    output logic [NUM_REQ-1:0]    reqAck,
    output logic [1:0]            sLo,
    output logic [1:0]            sHi,
    output logic                  enpN,
    output logic                  entNLo,
    output logic [7:0]            ctrData,
    output logic                  busy
);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [7:0]           data_hi_q, data_hi_d;
    logic [1:0]           s_lo_q, s_lo_d, s_hi_q, s_hi_d;
    logic                 enp_n_q, enp_n_d, ent_n_lo_q, ent_n_lo_d;
    logic [7:0]           ctr_data_q, ctr_data_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;

    logic [NUM_REQ-1:0]   grant;
    logic                 grant_en;
    logic [1:0]           sel_op_raw;
    logic [15:0]          sel_data;
    op_e                  sel_op;

    assign grant_en = (state_q == IDLE) && (|reqValid);

    ctr867_arbiter #(.NUM_REQ(NUM_REQ)) u_arbiter (
        .clk        (clk),
        .asyncResetN(asyncResetN),
        .req        (reqValid),
        .grant_en   (grant_en),
        .grant      (grant)
    );

    always_comb begin
        sel_op_raw = '0;
        sel_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op_raw = sel_op_raw | reqOp[2*i +: 2];
                sel_data   = sel_data | reqData[16*i +: 16];
            end
        end
        sel_op = op_e'(sel_op_raw);
    end

    // Pin registers are loaded with the values for the state being entered, so pins never see req* combinationally.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        data_hi_d  = data_hi_q;
        s_lo_d     = S_UP;
        s_hi_d     = S_UP;
        enp_n_d    = 1'b1;
        ent_n_lo_d = 1'b1;
        ctr_data_d = 8'h00;
        ack_d      = '0;
        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    gnt_d     = grant;
                    data_hi_d = sel_data[15:8];
                    if (sel_op == OP_LOAD) begin
                        state_d    = LOAD_LO;
                        s_lo_d     = S_LOAD;
                        ctr_data_d = sel_data[7:0];
                    end else begin
                        state_d = EXEC;
                        ack_d   = grant;
                        case (sel_op)
                            OP_CLR: begin
                                s_lo_d = S_CLR;
                                s_hi_d = S_CLR;
                            end
                            OP_DEC: begin
                                s_lo_d     = S_DOWN;
                                s_hi_d     = S_DOWN;
                                enp_n_d    = 1'b0;
                                ent_n_lo_d = 1'b0;
                            end
                            default: begin
                                enp_n_d    = 1'b0;
                                ent_n_lo_d = 1'b0;
                            end
                        endcase
                    end
                end
            end
            EXEC:    state_d = IDLE;
            LOAD_LO: begin
                state_d    = LOAD_HI;
                s_hi_d     = S_LOAD;
                ctr_data_d = data_hi_q;
                ack_d      = gnt_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge asyncResetN) begin
        if (!asyncResetN) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            data_hi_q  <= 8'h00;
            s_lo_q     <= S_UP;
            s_hi_q     <= S_UP;
            enp_n_q    <= 1'b1;
            ent_n_lo_q <= 1'b1;
            ctr_data_q <= 8'h00;
            ack_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            data_hi_q  <= data_hi_d;
            s_lo_q     <= s_lo_d;
            s_hi_q     <= s_hi_d;
            enp_n_q    <= enp_n_d;
            ent_n_lo_q <= ent_n_lo_d;
            ctr_data_q <= ctr_data_d;
            ack_q      <= ack_d;
        end
    end

    assign sLo     = s_lo_q;
    assign sHi     = s_hi_q;
    assign enpN    = enp_n_q;
    assign entNLo  = ent_n_lo_q;
    assign ctrData = ctr_data_q;
    assign reqAck  = ack_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ctr867_sequencer.sv
// Self-checking bench: behavioural chip-pair model plus a 16-bit reference value and arbitration predictor.
module tb_ctr867_sequencer;

    localparam int NUM_REQ = 3;
    localparam logic [1:0] C_CLR = 2'b00, C_DEC = 2'b01, C_LOAD = 2'b10, C_INC = 2'b11;

    logic                  clk = 1'b0;
    logic                  asyncResetN;
    logic [NUM_REQ-1:0]    reqValid;
    logic [2*NUM_REQ-1:0]  reqOp;
    logic [16*NUM_REQ-1:0] reqData;
    logic [NUM_REQ-1:0]    reqAck;
    logic [1:0]            sLo, sHi;
    logic                  enpN, entNLo, busy;
    logic [7:0]            ctrData;

    ctr867_sequencer #(.NUM_REQ(NUM_REQ)) dut (
        .clk(clk), .asyncResetN(asyncResetN), .reqValid(reqValid), .reqOp(reqOp),
        .reqData(reqData), .reqAck(reqAck), .sLo(sLo), .sHi(sHi), .enpN(enpN),
        .entNLo(entNLo), .ctrData(ctrData), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural model of the two cascaded counter chips driven from the DUT pins.
    logic [7:0] lo = 8'h00, hi = 8'h00;
    logic       rco_n_lo;
    assign rco_n_lo = !(!entNLo && ((sLo == 2'b11 && lo == 8'hFF) || (sLo == 2'b01 && lo == 8'h00)));

    function automatic logic [7:0] chip_next(input logic [7:0] q, input logic [1:0] s,
                                             input logic enp_n, input logic ent_n, input logic [7:0] d);
        case (s)
            2'b00:   return 8'h00;
            2'b01:   return (!enp_n && !ent_n) ? q - 8'd1 : q;
            2'b10:   return d;
            default: return (!enp_n && !ent_n) ? q + 8'd1 : q;
        endcase
    endfunction

    always @(posedge clk) begin
        lo <= chip_next(lo, sLo, enpN, entNLo, ctrData);
        hi <= chip_next(hi, sHi, enpN, rco_n_lo, ctrData);
    end

    // Pin-level watchdogs accumulated over the whole run.
    int s00_cnt = 0, leak_cnt = 0, hold_viol = 0;
    always @(negedge clk) begin
        if (sLo == 2'b00 || sHi == 2'b00) s00_cnt <= s00_cnt + 1;
        if (ctrData != 8'h00 && sLo != 2'b10 && sHi != 2'b10) leak_cnt <= leak_cnt + 1;
        if (!busy && (sLo != 2'b11 || sHi != 2'b11 || !enpN || !entNLo || ctrData != 8'h00 || reqAck != '0))
            hold_viol <= hold_viol + 1;
    end

    int          checks = 0, failures = 0;
    logic [15:0] ref_val = 16'h0000;
    int          rr_ptr = 0;
    int          clr_cnt = 0;
    logic [1:0]  tb_op   [NUM_REQ];
    logic [15:0] tb_data [NUM_REQ];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int predict(input logic [NUM_REQ-1:0] m);
        int base;
`ifdef CTR867_SEQ_RR_EN
        base = rr_ptr;
`else
        base = 0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            if (m[(base + k) % NUM_REQ]) return (base + k) % NUM_REQ;
        end
        return 0;
    endfunction

    function automatic logic [15:0] apply(input logic [15:0] v, input logic [1:0] op, input logic [15:0] d);
        case (op)
            C_CLR:   return 16'h0000;
            C_DEC:   return v - 16'd1;
            C_LOAD:  return d;
            default: return v + 16'd1;
        endcase
    endfunction

    task automatic drive(input logic [NUM_REQ-1:0] m);
        for (int i = 0; i < NUM_REQ; i++) begin
            reqOp[2*i +: 2]    = tb_op[i];
            reqData[16*i +: 16] = tb_data[i];
        end
        reqValid = m;
    endtask

    // Issue one arbitration round and check every pin cycle until the IDLE cycle after the ack.
    task automatic run_cmd(input logic [NUM_REQ-1:0] m);
        int          g;
        logic [1:0]  op, es;
        logic [15:0] d;
        logic        en;
        g  = predict(m);
        op = tb_op[g];
        d  = tb_data[g];
        drive(m);
        tick();
        check("busy_after_grant", 32'(busy), 32'd1);
        if (op == C_LOAD) begin
            check("load_lo_s", {28'd0, sLo, sHi}, {28'd0, 2'b10, 2'b11});
            check("load_lo_data", 32'(ctrData), 32'(d[7:0]));
            check("load_lo_en", {30'd0, enpN, entNLo}, 32'd3);
            check("load_lo_noack", 32'(reqAck), 32'd0);
            tick();
            check("load_hi_s", {28'd0, sLo, sHi}, {28'd0, 2'b11, 2'b10});
            check("load_hi_data", 32'(ctrData), 32'(d[15:8]));
            check("load_hi_en", {30'd0, enpN, entNLo}, 32'd3);
        end else begin
            es = (op == C_CLR) ? 2'b00 : (op == C_DEC) ? 2'b01 : 2'b11;
            en = (op == C_CLR);
            check("exec_s", {28'd0, sLo, sHi}, {28'd0, es, es});
            if (op != C_CLR) check("exec_en", {30'd0, enpN, entNLo}, {30'd0, en, en});
            check("exec_data", 32'(ctrData), 32'd0);
        end
        check("ack", 32'(reqAck), 32'd1 << g);
        reqValid = '0;
        ref_val  = apply(ref_val, op, d);
        rr_ptr   = (g + 1) % NUM_REQ;
        if (op == C_CLR) clr_cnt++;
        tick();
        check("value", {16'd0, hi, lo}, {16'd0, ref_val});
        check("idle_after_ack", {30'd0, busy, |reqAck}, 32'd0);
    endtask

    task automatic set_cmd(input int r, input logic [1:0] op, input logic [15:0] d);
        tb_op[r]   = op;
        tb_data[r] = d;
    endtask

    initial begin
        logic [NUM_REQ-1:0] m;
        int                 n_acks, exp_g;

        asyncResetN = 1'b0;
        reqValid    = '0;
        reqOp       = '0;
        reqData     = '0;
        for (int i = 0; i < NUM_REQ; i++) set_cmd(i, C_INC, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_s", {28'd0, sLo, sHi}, 32'hF);
        check("rst_en", {30'd0, enpN, entNLo}, 32'd3);
        check("rst_data", 32'(ctrData), 32'd0);
        check("rst_ack", 32'(reqAck), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        #2 asyncResetN = 1'b1;
        tick();

        // Directed sequence: load, carry across bytes, wraps, clear.
        set_cmd(0, C_LOAD, 16'h12AB); run_cmd(NUM_REQ'(1));
        set_cmd(0, C_LOAD, 16'h00FF); run_cmd(NUM_REQ'(1));
        set_cmd(0, C_INC,  16'h0000); run_cmd(NUM_REQ'(1));
        set_cmd(0, C_LOAD, 16'h0000); run_cmd(NUM_REQ'(1));
        set_cmd(0, C_DEC,  16'h0000); run_cmd(NUM_REQ'(1));
        set_cmd(0, C_CLR,  16'h0000); run_cmd(NUM_REQ'(1));
        set_cmd(1, C_LOAD, 16'hFFFF); run_cmd(NUM_REQ'(2));
        set_cmd(2, C_INC,  16'h0000); run_cmd(NUM_REQ'(4));
        set_cmd(1, C_LOAD, 16'h0100); run_cmd(NUM_REQ'(2));
        set_cmd(0, C_DEC,  16'h0000); run_cmd(NUM_REQ'(1));

        // Two requesters holding INC continuously.
        set_cmd(0, C_INC, 16'h0000);
        set_cmd(1, C_INC, 16'h0000);
        m = NUM_REQ'(3);
        drive(m);
        n_acks = 0;
        for (int c = 0; c < 24 && n_acks < 4; c++) begin
            tick();
            if (reqAck != '0) begin
                exp_g = predict(m);
                check("contend_ack", 32'(reqAck), 32'd1 << exp_g);
                rr_ptr  = (exp_g + 1) % NUM_REQ;
                ref_val = ref_val + 16'd1;
                n_acks++;
                if (n_acks == 4) reqValid = '0;
            end
        end
        reqValid = '0;
        check("contend_ack_count", 32'(n_acks), 32'd4);
        tick();
        check("contend_value", {16'd0, hi, lo}, {16'd0, ref_val});

        // Randomised commands from random requester subsets.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                tb_op[i]   = 2'($urandom_range(0, 3));
                tb_data[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            end
            run_cmd(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)));
        end

        // Asynchronous reset in the middle of LOAD_HI.
        set_cmd(0, C_LOAD, 16'h5AC3);
        drive(NUM_REQ'(1));
        tick();
        tick();
        check("pre_reset_load_hi", {28'd0, sLo, sHi}, {28'd0, 2'b11, 2'b10});
        #2 asyncResetN = 1'b0;
        #1;
        check("mid_rst_s", {28'd0, sLo, sHi}, 32'hF);
        check("mid_rst_en", {30'd0, enpN, entNLo}, 32'd3);
        check("mid_rst_data", 32'(ctrData), 32'd0);
        check("mid_rst_ack", 32'(reqAck), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        reqValid = '0;
        @(posedge clk);
        #3 asyncResetN = 1'b1;
        ref_val = {ref_val[15:8], 8'hC3};
        rr_ptr  = 0;
        tick();
        check("post_rst_idle", {30'd0, busy, |reqAck}, 32'd0);
        check("post_rst_value", {16'd0, hi, lo}, {16'd0, ref_val});
        set_cmd(0, C_INC, 16'h0000); run_cmd(NUM_REQ'(1));

        check("s00_only_in_clr", 32'(s00_cnt), 32'(clr_cnt));
        check("data_outside_load", 32'(leak_cnt), 32'd0);
        check("hold_when_idle", 32'(hold_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctr867_sequencer.md
CTR867_SEQUENCER -- requirements
Module: ctr867_sequencer

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (legal 2..4).
REQ-002 SHALL have port clk, input, 1, system clock, shared with both counter chips.
REQ-003 SHALL have port asyncResetN, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port reqValid, input, NUM_REQ, per-requester command valid.
REQ-005 SHALL have port reqOp, input, 2*NUM_REQ, per-requester opcode: 00 CLR, 01 DEC, 10 LOAD, 11 INC.
REQ-006 SHALL have port reqData, input, 16*NUM_REQ, per-requester load value.
REQ-007 SHALL have port reqAck, output, NUM_REQ, one-hot, one-cycle completion pulse.
REQ-008 SHALL have port sLo, output, 2, S select of the low-byte chip.
REQ-009 SHALL have port sHi, output, 2, S select of the high-byte chip.
REQ-010 SHALL have port enpN, output, 1, shared count enable P, active-low.
REQ-011 SHALL have port entNLo, output, 1, low-chip count enable T, active-low; high-chip entN is wired externally to low-chip rcoN.
REQ-012 SHALL have port ctrData, output, 8, shared byte bus to both chips' data inputs.
REQ-013 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-014 SHALL keep all chip-side outputs registered; no combinational path from req* to chip pins.
REQ-015 SHALL drive HOLD (sLo=sHi=11, enpN=1, entNLo=1) in every cycle not executing an operation.
REQ-016 SHALL never drive S=00 on either chip except in the CLR cycle, as S=00 clears the chip asynchronously.
REQ-017 SHALL use FSM states IDLE, EXEC, LOAD_LO, LOAD_HI.
REQ-018 IDLE: when any reqValid is high, SHALL grant one requester per REQ-029, latch its op/data and go to EXEC (CLR/INC/DEC) or LOAD_LO (LOAD).
REQ-019 EXEC: SHALL present the op for exactly one cycle (CLR: sLo=sHi=00; INC: S=11, enpN=0, entNLo=0; DEC: S=01, enpN=0, entNLo=0), pulse reqAck of the grantee, return to IDLE.
REQ-020 LOAD_LO: SHALL present sLo=10, sHi=11, enables high, ctrData=data[7:0] for one cycle, then go to LOAD_HI.
REQ-021 LOAD_HI: SHALL present sLo=11, sHi=10, enables high, ctrData=data[15:8] for one cycle, pulse reqAck, return to IDLE.
REQ-022 Latency from grant edge to ack: 1 cycle for CLR/INC/DEC, 2 cycles for LOAD; counter value updates at the clock edge ending the ack cycle (CLR immediately on entering it).
REQ-023 SHALL ignore reqValid changes while busy; the granted command is latched at grant and not re-sampled.
REQ-024 A requester SHALL hold reqValid until its ack; reqValid still high in the cycle after ack is a new command.
REQ-025 INC from 0xFFFF SHALL wrap to 0x0000 and DEC from 0x0000 to 0xFFFF via the external cascade; no special handling.
REQ-026 ctrData SHALL be 0x00 outside LOAD_LO/LOAD_HI.
REQ-027 Back-to-back: IDLE SHALL last at least one cycle between consecutive operations (HOLD cycle).

Reset
REQ-028 While asyncResetN=0: state IDLE, sLo=sHi=11, enpN=1, entNLo=1, ctrData=0x00, reqAck=0, busy=0, round-robin pointer=0; release is synchronous to clk for the FSM.

Configuration
REQ-029 With CTR867_SEQ_RR_EN defined, arbitration SHALL be round-robin: search starts at index after last grantee; without it, fixed priority, lowest index wins.

Structure
REQ-030 Package ctr867_pkg SHALL hold the opcode enum (CLR/DEC/LOAD/INC), the chip S encodings (S_CLR=00, S_DOWN=01, S_LOAD=10, S_UP=11) and the FSM state enum.
REQ-031 Arbiter SHALL be a sub-module ctr867_arbiter (request vector in, one-hot grant out, pointer update on grant).

Verification
REQ-032 Reset, then req0 LOAD 0x12AB -> LOAD_LO ctrData=0xAB sLo=10, LOAD_HI ctrData=0x12 sHi=10, reqAck[0] on cycle 2, chip model reads 0x12AB.
REQ-033 Load 0x00FF, req0 INC -> one cycle enpN=entNLo=0 S=11, chip pair reads 0x0100.
REQ-034 Load 0x0000, DEC -> 0xFFFF; then CLR -> S=00 one cycle, 0x0000, S=00 never seen in any other cycle.
REQ-035 req0 and req1 INC valid continuously: with CTR867_SEQ_RR_EN acks alternate 0,1,0,1; without it only reqAck[0] pulses.
REQ-036 Assert asyncResetN=0 during LOAD_HI -> outputs immediately at HOLD/0x00, no ack, FSM IDLE after release.
